// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: grant state encoding and
// the default read data returned on a timed-out transaction.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Transaction watchdog: counts stalled cycles while enabled and flags the cycle
// in which the budget of TIMEOUT_CYCLES is used up.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between CPU (m0) and DMA (m1) onto the single slave bus,
// with a watchdog that force-completes transactions the slave never answers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_addr,
  output logic        err_master
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_master_q, err_master_d;

  logic        gnt;
  logic        sel;
  logic        sel_valid;
  logic [31:0] sel_addr;
  logic        wd_expire;
  logic        timeout;
  logic        ack;
  logic [31:0] ack_data;

  assign gnt = (state_q != IDLE);
  assign sel = (state_q == GNT1);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (!gnt),
    .en     (gnt && !s_ready),
    .expire (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_valid    = sel ? m1_valid : m0_valid;
    sel_addr     = sel ? m1_addr : m0_addr;
    timeout      = gnt && wd_expire && !s_ready;
    ack          = gnt && (s_ready || timeout);
    ack_data     = '0;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;

    case (state_q)
      IDLE: begin
        // m0 wins unless m1 also requests and m0 was the last one served
        if (m0_valid && (!m1_valid || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (m1_valid) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        s_addr  = sel_addr;
        s_wdata = sel ? m1_wdata : m0_wdata;
        s_wstrb = sel ? m1_wstrb : m0_wstrb;
        s_valid = sel_valid && !timeout;
        if (timeout) begin
          ack_data = ERR_DATA;
        end else if (s_ready) begin
          ack_data = s_rdata;
        end
        if (s_ready || !sel_valid || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    m0_ready = ack && !sel;
    m1_ready = ack && sel;
    m0_rdata = sel ? '0 : ack_data;
    m1_rdata = sel ? ack_data : '0;

    // a timeout in the same cycle as err_clr keeps the flag set
    bus_err_d    = timeout ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
    err_addr_d   = timeout ? sel_addr : err_addr_q;
    err_master_d = timeout ? sel : err_master_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      bus_err_q    <= 1'b0;
      err_addr_q   <= '0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_err_q    <= bus_err_d;
      err_addr_q   <= err_addr_d;
      err_master_q <= err_master_d;
    end
  end

  assign bus_err    = bus_err_q;
  assign err_addr   = err_addr_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: completions are checked against a scoreboard
// of expected (master, rdata) pairs; bus-side signals are checked inline.
module tb_bus_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        err_master;

  typedef struct packed {
    logic        m;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  bus_arbiter #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_valid  (m0_valid),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .err_clr   (err_clr),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .err_master(err_master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // completion monitor: every ready pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (m0_ready || m1_ready) begin
      exp_t e;
      chk("one_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_master", {31'd0, m1_ready}, {31'd0, e.m});
        chk("ack_rdata", m1_ready ? m1_rdata : m0_rdata, e.d);
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
    err_clr  = 1'b0;

    repeat (2) nxt();
    smp();
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_err_master", {31'd0, err_master}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    nxt();
    reset_n = 1'b1;

    // round robin with both masters holding requests, slave always ready
    m0_addr = 32'h0000_0100;
    m1_addr = 32'h0000_0200;
    for (int i = 0; i < 8; i++) begin
      nxt();
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      s_ready  = 1'b1;
      s_rdata  = 32'hA000_0000 + i;
      if (i % 2 == 1) sb.push_back('{m: ((i / 2) % 2 == 1), d: 32'hA000_0000 + i});
      smp();
      chk("rr_s_valid", {31'd0, s_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) chk("rr_s_addr", s_addr, ((i / 2) % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
    end
    nxt();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    smp();
    chk("rr_end_idle", {31'd0, s_valid}, 32'd0);

    // m0 read, slave answers on the third granted cycle
    nxt();
    m0_valid = 1'b1; m0_addr = 32'h0002_0010; m0_wstrb = 4'h0;
    smp();
    chk("rd_arb_cycle", {31'd0, s_valid}, 32'd0);
    nxt();
    smp();
    chk("rd_s_valid", {31'd0, s_valid}, 32'd1);
    chk("rd_s_addr", s_addr, 32'h0002_0010);
    chk("rd_s_wstrb", {28'd0, s_wstrb}, 32'd0);
    nxt();
    smp();
    chk("rd_wait_ready", {31'd0, m0_ready}, 32'd0);
    nxt();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    sb.push_back('{m: 1'b0, d: 32'h1234_5678});
    smp();
    chk("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
    nxt();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    smp();
    chk("rd_after_idle", {31'd0, s_valid}, 32'd0);

    // m1 write forwarded unchanged
    nxt();
    m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'h0000_002A; m1_wstrb = 4'hF;
    smp();
    nxt();
    smp();
    chk("wr_s_valid", {31'd0, s_valid}, 32'd1);
    chk("wr_s_addr", s_addr, 32'h8000_0000);
    chk("wr_s_wdata", s_wdata, 32'h0000_002A);
    chk("wr_s_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
    nxt();
    s_ready = 1'b1; s_rdata = 32'h5555_0000;
    sb.push_back('{m: 1'b1, d: 32'h5555_0000});
    smp();
    nxt();
    m1_valid = 1'b0; m1_wstrb = 4'h0; s_ready = 1'b0; s_rdata = '0;
    smp();

    // m0 timeout: forced completion on the 8th granted cycle
    nxt();
    m0_valid = 1'b1; m0_addr = 32'h4000_0000;
    smp();
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (k == 8) sb.push_back('{m: 1'b0, d: 32'hDEAD_BEEF});
      smp();
      chk("to0_s_valid", {31'd0, s_valid}, (k == 8) ? 32'd0 : 32'd1);
    end
    nxt();
    m0_valid = 1'b0;
    smp();
    chk("to0_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to0_err_addr", err_addr, 32'h4000_0000);
    chk("to0_err_master", {31'd0, err_master}, 32'd0);

    // m1 served normally after the timeout
    nxt();
    m1_valid = 1'b1; m1_addr = 32'h0000_0010;
    smp();
    nxt();
    smp();
    chk("post_to_s_valid", {31'd0, s_valid}, 32'd1);
    nxt();
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    sb.push_back('{m: 1'b1, d: 32'h0000_0077});
    smp();
    nxt();
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    smp();

    // m1 timeout coinciding with err_clr: the set wins
    nxt();
    m1_valid = 1'b1; m1_addr = 32'h9000_0004;
    smp();
    for (int k = 1; k <= 8; k++) begin
      nxt();
      if (k == 8) begin
        err_clr = 1'b1;
        sb.push_back('{m: 1'b1, d: 32'hDEAD_BEEF});
      end
      smp();
    end
    nxt();
    err_clr = 1'b0; m1_valid = 1'b0;
    smp();
    chk("to1_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to1_err_addr", err_addr, 32'h9000_0004);
    chk("to1_err_master", {31'd0, err_master}, 32'd1);
    nxt();
    err_clr = 1'b1;
    smp();
    nxt();
    err_clr = 1'b0;
    smp();
    chk("clr_bus_err", {31'd0, bus_err}, 32'd0);
    chk("clr_err_addr", err_addr, 32'h9000_0004);
    chk("clr_err_master", {31'd0, err_master}, 32'd1);

    // asynchronous reset while m1 is granted and the slave stalls
    nxt();
    m1_valid = 1'b1; m1_addr = 32'hC000_0000;
    smp();
    nxt();
    smp();
    chk("stall_s_valid", {31'd0, s_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("arst_s_addr", s_addr, 32'd0);
    chk("arst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("arst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("arst_err_addr", err_addr, 32'd0);
    chk("arst_err_master", {31'd0, err_master}, 32'd0);
    m1_valid = 1'b0;
    repeat (2) nxt();
    reset_n = 1'b1;

    nxt();
    m0_valid = 1'b1; m0_addr = 32'h0000_0044;
    smp();
    nxt();
    smp();
    chk("post_rst_s_valid", {31'd0, s_valid}, 32'd1);
    chk("post_rst_s_addr", s_addr, 32'h0000_0044);
    nxt();
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    sb.push_back('{m: 1'b0, d: 32'h0BAD_F00D});
    smp();
    nxt();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    smp();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout_guard observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
